irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised interrupt controller; successor to the fixed pending-latch plus priority-encoder logic in the MCU top.
- Accepts up to 15 request lines, each with its own enable and edge/level mode.
- Presents one 4-bit vector to the chad CPU and retires the serviced request on iack.
- Register-mapped on the CPU I/O bus; software can read, clear and set pending bits.

Parameters:
- IRQS, 8, number of request sources (1..15); source i maps to vector i+1.
- WIDTH, 24, I/O data width; must be >= IRQS+1.
- MODE_RST, 0, reset value of the MODE register (bit i = 1 puts source i in level mode).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- src  input  IRQS  raw request lines.
- io_wr  input  1  register write strobe.
- io_rd  input  1  register read strobe.
- addr  input  2  register select.
- din  input  WIDTH  write data.
- dout  output  WIDTH  read data, registered.
- irq  output  1  interrupt request to CPU; high when ivec != 0.
- ivec  output  4  highest-priority active vector; 0 = none.
- iack  input  1  CPU acknowledge of the current ivec.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: pending = 0, enable = 0, mode = MODE_RST, prev = all ones (no spurious edge at reset release), dout = 0, so irq = 0 and ivec = 0.
- Bit numbering: pending, enable, mode and prev are IRQS wide; bit i corresponds to vector i+1.
- Edge mode (mode[i] = 0):
  - edge[i] = s[i] & ~prev[i], where s is the sampled request.
  - prev <= s every cycle.
- Level mode (mode[i] = 1): edge[i] = s[i] every cycle.
- Pending update on each clk edge: pending[i] <= (pending[i] & ~clr[i]) | edge[i] | swset[i].
  - Set always beats clear in the same cycle, so no event is lost.
  - clr[i] is the OR of:
    - iack with ivec == i+1;
    - io_wr to addr 0 with din[i] = 1.
- Priority: act = pending & enable; ivec = index+1 of the highest set bit of act (highest vector wins).
  - ivec and irq are combinational from registers; no combinational path from src or io inputs.
- Acknowledge: iack clears the pending bit named by ivec in the same cycle. iack while ivec == 0 is ignored.
  - A level source still asserted re-pends on the same edge, so irq stays high.
- Latency, src to irq:
  - src rising before clk edge k gives pending set after edge k; irq is visible in cycle k+1 (with enable set).
  - With IRQ_SYNC_EN the latency is 2 cycles more.
- Register map:
  - addr 0 PENDING: read = pending; write = 1-to-clear.
  - addr 1 ENABLE: read/write.
  - addr 2 MODE: read/write.
  - addr 3 STATUS: read = {irq, ivec} in bits [4:0]; write = 1-to-set pending (swset). Software set works in either mode.
- Writes take effect at the strobe's clk edge.
  - Disabling a source keeps its pending bit; it is presented again when re-enabled.
  - A mode change clears nothing.
- Reads:
  - dout <= selected register, zero-extended, on the edge where io_rd is high; valid the following cycle.
  - dout holds its value otherwise.
  - Unused upper bits read 0.
- Simultaneous io_rd and io_wr to the same address: read returns the pre-write value.
- Mid-operation reset: all state returns to reset values in one cycle; requests in flight are discarded.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - Each src bit passes through a two-flop synchronizer (reset value 0) before edge detection.
  - Sources may be asynchronous to clk.
  - src-to-irq latency is 3 cycles.
- Undefined: src is sampled directly and must be synchronous to clk; latency is 1 cycle.

Test Plan:
- Post-reset baseline: hold src = 8'hFF through reset, release, set enable = 8'hFF, mode = 0 -> no pending bits; irq = 0; ivec = 0.
- Edge and priority:
  - src[2] and src[5] pulse in the same cycle with enable = 8'hFF -> ivec = 6.
  - After iack -> ivec = 3.
  - After second iack -> ivec = 0; PENDING reads 0.
- Level re-pend: mode[0] = 1, src[0] held high, iack -> ivec stays 1 and irq stays high; drop src[0] then iack -> ivec = 0.
- Simultaneous set/clear: src[3] edge in the same cycle as a PENDING write of 8'h08 -> PENDING reads 8'h08 afterwards.
- Mask, software set and status:
  - enable = 0, write STATUS with 8'h10 -> PENDING = 8'h10, irq = 0.
  - enable = 8'h10 -> ivec = 5; STATUS reads 5'h15.
- Reset mid-operation: PENDING = 8'h81, enable = 8'hFF, pulse rst one cycle -> next cycle PENDING = 0, ENABLE = 0, irq = 0, dout = 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: up to 15 edge/level sources with enable, pending and a 4-bit vector.
// Define IRQ_SYNC_EN to add a two-flop synchronizer on every src bit.
module irq_ctrl #(
    parameter int unsigned    IRQS     = 8,
    parameter int unsigned    WIDTH    = 24,
    parameter logic [IRQS-1:0] MODE_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQS-1:0]  src,
    input  logic             io_wr,
    input  logic             io_rd,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq,
    output logic [3:0]       ivec,
    input  logic             iack
);

    logic [IRQS-1:0]  pend_q, en_q, mode_q, prev_q;
    logic [IRQS-1:0]  s, edg, act, ack_clr, wr_clr, swset, clr;
    logic [WIDTH-1:0] dout_q, rd_data;
    logic [3:0]       ivec_c;
    logic             unused_din;

    assign unused_din = ^din[WIDTH-1:IRQS];

`ifdef IRQ_SYNC_EN
    logic [IRQS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = src;
`endif

    // Level-mode sources bypass the previous-sample gate.
    assign edg = s & (mode_q | ~prev_q);
    assign act = pend_q & en_q;

    always_comb begin
        ivec_c = 4'd0;
        for (int unsigned i = 0; i < IRQS; i++) begin
            if (act[i]) ivec_c = 4'(i + 1);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < IRQS; i++) begin
            ack_clr[i] = iack && (ivec_c == 4'(i + 1));
        end
    end

    assign wr_clr = (io_wr && addr == 2'd0) ? din[IRQS-1:0] : '0;
    assign swset  = (io_wr && addr == 2'd3) ? din[IRQS-1:0] : '0;
    assign clr    = ack_clr | wr_clr;

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0:    rd_data = WIDTH'(pend_q);
            2'd1:    rd_data = WIDTH'(en_q);
            2'd2:    rd_data = WIDTH'(mode_q);
            default: rd_data = WIDTH'({irq, ivec_c});
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            en_q   <= '0;
            mode_q <= MODE_RST;
            prev_q <= '1;
            dout_q <= '0;
        end else begin
            // Set terms come last so a same-cycle clear never loses an event.
            pend_q <= (pend_q & ~clr) | edg | swset;
            prev_q <= s;
            if (io_wr && addr == 2'd1) en_q <= din[IRQS-1:0];
            if (io_wr && addr == 2'd2) mode_q <= din[IRQS-1:0];
            if (io_rd) dout_q <= rd_data;
        end
    end

    assign ivec = ivec_c;
    assign irq  = (ivec_c != 4'd0);
    assign dout = dout_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl with default parameters (IRQS=8, WIDTH=24).
module tb_irq_ctrl;

    localparam int unsigned IRQS  = 8;
    localparam int unsigned WIDTH = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [IRQS-1:0]  src;
    logic             io_wr, io_rd, iack;
    logic [1:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             irq;
    logic [3:0]       ivec;
    logic [WIDTH-1:0] rd;

    int n_vec = 0;
    int n_err = 0;

    irq_ctrl #(.IRQS(IRQS), .WIDTH(WIDTH), .MODE_RST(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .src   (src),
        .io_wr (io_wr),
        .io_rd (io_rd),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq   (irq),
        .ivec  (ivec),
        .iack  (iack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
        io_wr = 1'b1;
        addr  = a;
        din   = d;
        tick();
        io_wr = 1'b0;
        din   = '0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [WIDTH-1:0] d);
        io_rd = 1'b1;
        addr  = a;
        tick();
        io_rd = 1'b0;
        d     = dout;
    endtask

    task automatic ack();
        iack = 1'b1;
        tick();
        iack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src = 8'hFF; io_wr = 1'b0; io_rd = 1'b0; iack = 1'b0;
        addr = 2'd0; din = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ivec", 32'(ivec), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);

        // Held-high sources must not fire on reset release.
        reg_wr(2'd1, 24'hFF);
        reg_wr(2'd2, 24'h00);
        reg_rd(2'd0, rd);
        check("base_pend", 32'(rd), 32'h0);
        check("base_irq", 32'(irq), 32'h0);
        check("base_ivec", 32'(ivec), 32'h0);

        src = 8'h00;
        tick();
        src = 8'h24;
        tick();
        src = 8'h00;
        check("prio_ivec6", 32'(ivec), 32'h6);
        check("prio_irq", 32'(irq), 32'h1);
        ack();
        check("ack1_ivec3", 32'(ivec), 32'h3);
        ack();
        check("ack2_ivec0", 32'(ivec), 32'h0);
        reg_rd(2'd0, rd);
        check("ack2_pend", 32'(rd), 32'h0);

        // Level source re-pends on the acknowledging edge.
        reg_wr(2'd2, 24'h01);
        src = 8'h01;
        tick();
        check("lvl_ivec1", 32'(ivec), 32'h1);
        ack();
        check("lvl_repend_ivec", 32'(ivec), 32'h1);
        check("lvl_repend_irq", 32'(irq), 32'h1);
        src = 8'h00;
        ack();
        check("lvl_drop_ivec", 32'(ivec), 32'h0);
        reg_wr(2'd2, 24'h00);

        // Edge arriving with a write-1-to-clear on the same edge.
        src   = 8'h08;
        io_wr = 1'b1; addr = 2'd0; din = 24'h08;
        tick();
        io_wr = 1'b0; din = '0; src = 8'h00;
        reg_rd(2'd0, rd);
        check("setclr_pend", 32'(rd), 32'h08);
        reg_wr(2'd0, 24'hFF);
        reg_rd(2'd0, rd);
        check("w1c_pend", 32'(rd), 32'h0);

        reg_wr(2'd1, 24'h00);
        reg_wr(2'd3, 24'h10);
        reg_rd(2'd0, rd);
        check("swset_pend", 32'(rd), 32'h10);
        check("mask_irq", 32'(irq), 32'h0);
        reg_wr(2'd1, 24'h10);
        check("unmask_ivec", 32'(ivec), 32'h5);
        reg_rd(2'd3, rd);
        check("status", 32'(rd), 32'h15);
        tick();
        check("dout_hold", 32'(dout), 32'h15);

        // Read and write to the same register: read sees the old value.
        io_rd = 1'b1; io_wr = 1'b1; addr = 2'd1; din = 24'h3C;
        tick();
        io_rd = 1'b0; io_wr = 1'b0; din = '0;
        check("rdwr_old", 32'(dout), 32'h10);
        reg_rd(2'd1, rd);
        check("rdwr_new", 32'(rd), 32'h3C);

        reg_wr(2'd0, 24'hFF);
        reg_wr(2'd3, 24'h81);
        reg_wr(2'd1, 24'hFF);
        reg_wr(2'd2, 24'h02);
        reg_rd(2'd0, rd);
        check("pre_rst_pend", 32'(rd), 32'h81);
        check("pre_rst_ivec", 32'(ivec), 32'h8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_dout", 32'(dout), 32'h0);
        reg_rd(2'd0, rd);
        check("mid_rst_pend", 32'(rd), 32'h0);
        reg_rd(2'd1, rd);
        check("mid_rst_en", 32'(rd), 32'h0);
        reg_rd(2'd2, rd);
        check("mid_rst_mode", 32'(rd), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
